// File: rtl/swerv_trace_buf.sv
// Retire-trace capture buffer: splits up to three retired slots per cycle into
// per-instruction records and queues them for a valid/ready trace sink.
module swerv_trace_buf #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     trace_en,
    input  logic [2:0]               trace_rv_i_valid_ip,
    input  logic [95:0]              trace_rv_i_insn_ip,
    input  logic [95:0]              trace_rv_i_address_ip,
    input  logic [2:0]               trace_rv_i_exception_ip,
    input  logic [4:0]               trace_rv_i_ecause_ip,
    input  logic [2:0]               trace_rv_i_interrupt_ip,
    input  logic [31:0]              trace_rv_i_tval_ip,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_insn,
    output logic [31:0]              out_addr,
    output logic                     out_exc,
    output logic                     out_intr,
    output logic [4:0]               out_ecause,
    output logic [31:0]              out_tval,
    output logic [7:0]               out_seq,
    input  logic                     ovf_clr,
    output logic                     ovf_sticky,
    output logic [15:0]              drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Record storage (not reset)
    logic [31:0]   insn_mem_q   [DEPTH];
    logic [31:0]   addr_mem_q   [DEPTH];
    logic          exc_mem_q    [DEPTH];
    logic          intr_mem_q   [DEPTH];
    logic [4:0]    ecause_mem_q [DEPTH];
    logic [31:0]   tval_mem_q   [DEPTH];
    logic [7:0]    seq_mem_q    [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    seq_q, seq_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;

    logic [1:0]    n_s;
    logic [LW-1:0] free_s;
    logic          accept_s;
    logic          drop_s;
    logic          pop_s;
    logic [2:0]    we_s;
    logic [1:0]    off_s    [3];
    logic [AW-1:0] wr_idx_s [3];
    logic [7:0]    wr_seq_s [3];
    logic [16:0]   drop_sum_s;

    assign out_valid  = (level_q != {LW{1'b0}});
    assign ovf_sticky = ovf_q;
    assign drop_cnt   = drop_q;
    assign level      = level_q;

    // Admission decision, slot compression offsets and next-state values
    always_comb begin
        n_s        = 2'd0;
        we_s       = 3'b000;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        drop_d     = drop_q;
        ovf_d      = ovf_q;
        if (trace_en) begin
            n_s = popcnt3(trace_rv_i_valid_ip);
        end else begin
            n_s = 2'd0;
        end
        // Free space ignores a same-cycle pop on purpose
        free_s   = DEPTH_L - level_q;
        accept_s = (LW'(n_s) <= free_s);
        drop_s   = ~accept_s;
        pop_s    = out_valid & out_ready;

        off_s[0] = 2'd0;
        off_s[1] = {1'b0, trace_rv_i_valid_ip[0]};
        off_s[2] = popcnt3({1'b0, trace_rv_i_valid_ip[1:0]});
        for (int i = 0; i < 3; i++) begin
            wr_idx_s[i] = wptr_q + AW'(off_s[i]);
            wr_seq_s[i] = seq_q + 8'(off_s[i]);
        end

        if (accept_s) begin
            we_s   = trace_rv_i_valid_ip & {3{trace_en}};
            wptr_d = wptr_q + AW'(n_s);
        end else begin
            we_s   = 3'b000;
            wptr_d = wptr_q;
        end

        if (pop_s) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end

        level_d = level_q + (accept_s ? LW'(n_s) : {LW{1'b0}}) - LW'(pop_s);
        // Sequence advances by the group size whether accepted or dropped
        seq_d   = seq_q + 8'(n_s);

        drop_sum_s = {1'b0, drop_q} + 17'(n_s);
        if (drop_s) begin
            drop_d = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
            ovf_d  = 1'b1;
        end else if (ovf_clr) begin
            drop_d = drop_q;
            ovf_d  = 1'b0;
        end else begin
            drop_d = drop_q;
            ovf_d  = ovf_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            level_q <= {LW{1'b0}};
            seq_q   <= 8'd0;
            ovf_q   <= 1'b0;
            drop_q  <= 16'd0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Record storage writes; cause/tval kept only for trapping slots
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (we_s[i]) begin
                insn_mem_q[wr_idx_s[i]]   <= trace_rv_i_insn_ip[32*i +: 32];
                addr_mem_q[wr_idx_s[i]]   <= trace_rv_i_address_ip[32*i +: 32];
                exc_mem_q[wr_idx_s[i]]    <= trace_rv_i_exception_ip[i];
                intr_mem_q[wr_idx_s[i]]   <= trace_rv_i_interrupt_ip[i];
                ecause_mem_q[wr_idx_s[i]] <= (trace_rv_i_exception_ip[i] | trace_rv_i_interrupt_ip[i])
                                             ? trace_rv_i_ecause_ip : 5'd0;
                tval_mem_q[wr_idx_s[i]]   <= (trace_rv_i_exception_ip[i] | trace_rv_i_interrupt_ip[i])
                                             ? trace_rv_i_tval_ip : 32'd0;
                seq_mem_q[wr_idx_s[i]]    <= wr_seq_s[i];
            end
        end
    end

    // Head record view, zeroed while empty
    always_comb begin
        out_insn   = 32'd0;
        out_addr   = 32'd0;
        out_exc    = 1'b0;
        out_intr   = 1'b0;
        out_ecause = 5'd0;
        out_tval   = 32'd0;
        out_seq    = 8'd0;
        if (out_valid) begin
            out_insn   = insn_mem_q[rptr_q];
            out_addr   = addr_mem_q[rptr_q];
            out_exc    = exc_mem_q[rptr_q];
            out_intr   = intr_mem_q[rptr_q];
            out_ecause = ecause_mem_q[rptr_q];
            out_tval   = tval_mem_q[rptr_q];
            out_seq    = seq_mem_q[rptr_q];
        end else begin
            out_insn   = 32'd0;
        end
    end
endmodule
